// File: rtl/gpi_debounce_core.sv
// GPI slot core for the FPro MMIO bus: per-bit 2-FF synchroniser, programmable debouncer,
// sticky rise/fall capture with write-1-to-clear, and a maskable registered level interrupt.
module gpi_debounce_core #(
    parameter int N_IN       = 10,
    parameter int CNT_W      = 20,
    parameter int DB_DEFAULT = 500000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cs,
    input  logic            read,
    input  logic            write,
    input  logic [4:0]      addr,
    input  logic [31:0]     wr_data,
    output logic [31:0]     rd_data,
    input  logic [N_IN-1:0] din,
    output logic            irq
);

    localparam logic [4:0] ADDR_DATA   = 5'd0;
    localparam logic [4:0] ADDR_RISE   = 5'd1;
    localparam logic [4:0] ADDR_FALL   = 5'd2;
    localparam logic [4:0] ADDR_IEN    = 5'd3;
    localparam logic [4:0] ADDR_PERIOD = 5'd4;

    logic [N_IN-1:0]  s1_q, s2_q;
    logic [N_IN-1:0]  db_q, db_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];
    logic [N_IN-1:0]  rise_q, rise_d;
    logic [N_IN-1:0]  fall_q, fall_d;
    logic [N_IN-1:0]  ien_q, ien_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [N_IN-1:0]  wr_bits;
    logic [N_IN-1:0]  rise_clr, fall_clr;
    logic             unused_ok;

    assign wr_en    = cs & write;
    assign wr_bits  = wr_data[N_IN-1:0];
    assign rise_clr = (wr_en && addr == ADDR_RISE) ? wr_bits : '0;
    assign fall_clr = (wr_en && addr == ADDR_FALL) ? wr_bits : '0;

    // Reads are side-effect free, so the read strobe carries no information here.
    assign unused_ok = &{1'b0, read, wr_data};

    // Debouncer: the >= compare lets a lowered period release a long-running count at once.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        db_d = db_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= period_q) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge set is OR-ed in after the clear, so a same-cycle set beats a W1C.
    always_comb begin
        rise_d   = (rise_q & ~rise_clr) | (db_d & ~db_q);
        fall_d   = (fall_q & ~fall_clr) | (~db_d & db_q);
        ien_d    = ien_q;
        period_d = period_q;
        if (wr_en && addr == ADDR_IEN)    ien_d    = wr_bits;
        if (wr_en && addr == ADDR_PERIOD) period_d = wr_data[CNT_W-1:0];
        irq_d    = |((rise_q | fall_q) & ien_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            ien_q    <= '0;
            period_q <= CNT_W'(DB_DEFAULT);
            irq_q    <= 1'b0;
            // NOTE: the counter array is a set of per-bit registers, not a RAM, so it is reset.
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_q     <= din;
            s2_q     <= s1_q;
            db_q     <= db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            ien_q    <= ien_d;
            period_q <= period_d;
            irq_q    <= irq_d;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA:   rd_data = 32'(db_q);
            ADDR_RISE:   rd_data = 32'(rise_q);
            ADDR_FALL:   rd_data = 32'(fall_q);
            ADDR_IEN:    rd_data = 32'(ien_q);
            ADDR_PERIOD: rd_data = 32'(period_q);
            default:     rd_data = '0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_gpi_debounce_core.sv
// Scoreboard bench for gpi_debounce_core: expectations are queued alongside the matching
// observations and each scenario task drains and compares its own pairs.
module tb_gpi_debounce_core;

    localparam int N_IN       = 10;
    localparam int CNT_W      = 20;
    localparam int DB_DEFAULT = 500000;

    logic            clk;
    logic            reset_n;
    logic            cs;
    logic            read;
    logic            write;
    logic [4:0]      addr;
    logic [31:0]     wr_data;
    logic [31:0]     rd_data;
    logic [N_IN-1:0] din;
    logic            irq;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] act_q[$];
    int          checks = 0;
    int          errors = 0;

    gpi_debounce_core #(
        .N_IN      (N_IN),
        .CNT_W     (CNT_W),
        .DB_DEFAULT(DB_DEFAULT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .cs     (cs),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .din    (din),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write is sampled on the next rising edge; returns 1 unit after that edge.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic exp_reg(input string name, input logic [4:0] a, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        act_q.push_back(rd_data);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic exp_irq(input string name, input logic v);
        exp_t e;
        e.name = name;
        e.val  = {31'b0, v};
        exp_q.push_back(e);
        act_q.push_back({31'b0, irq});
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] a;
        exp_reg("reset_period", 5'd4, 32'd500000);
        exp_reg("reset_data",   5'd0, 32'h0);
        exp_reg("reset_rise",   5'd1, 32'h0);
        exp_reg("reset_fall",   5'd2, 32'h0);
        exp_reg("reset_ien",    5'd3, 32'h0);
        exp_irq("reset_irq", 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_latency();
        exp_t e;
        logic [31:0] a;
        bus_write(5'd4, 32'd4);
        din[0] = 1'b1;
        tick(6);
        exp_reg("lat_data_edge6", 5'd0, 32'h000);
        tick(1);
        exp_reg("lat_data_edge7", 5'd0, 32'h001);
        exp_reg("lat_rise",       5'd1, 32'h001);
        exp_reg("lat_fall",       5'd2, 32'h000);
        exp_reg("lat_period",     5'd4, 32'd4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        logic [31:0] a;
        bus_write(5'd1, 32'h3FF);
        bus_write(5'd2, 32'h3FF);
        din[3] = 1'b1;
        tick(4);
        din[3] = 1'b0;
        tick(12);
        exp_reg("glitch4_data", 5'd0, 32'h001);
        exp_reg("glitch4_rise", 5'd1, 32'h000);
        exp_reg("glitch4_fall", 5'd2, 32'h000);
        din[3] = 1'b1;
        tick(8);
        din[3] = 1'b0;
        exp_reg("glitch8_data", 5'd0, 32'h009);
        exp_reg("glitch8_rise", 5'd1, 32'h008);
        exp_reg("glitch8_fall", 5'd2, 32'h000);
        tick(12);
        exp_reg("release_data", 5'd0, 32'h001);
        exp_reg("release_rise", 5'd1, 32'h008);
        exp_reg("release_fall", 5'd2, 32'h008);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_irq();
        exp_t e;
        logic [31:0] a;
        bus_write(5'd1, 32'h3FF);
        bus_write(5'd2, 32'h3FF);
        bus_write(5'd3, 32'h002);
        din[1] = 1'b1;
        tick(7);
        exp_reg("irq_rise_set",     5'd1, 32'h002);
        exp_irq("irq_lag_one_edge", 1'b0);
        tick(1);
        exp_irq("irq_asserted", 1'b1);
        bus_write(5'd1, 32'h002);
        exp_reg("irq_rise_cleared", 5'd1, 32'h000);
        exp_irq("irq_held_one_edge", 1'b1);
        tick(1);
        exp_irq("irq_deasserted", 1'b0);
        bus_write(5'd3, 32'h000);
        din[1] = 1'b0;
        tick(9);
        exp_reg("irq_masked_fall", 5'd2, 32'h002);
        exp_reg("irq_ien_zero",    5'd3, 32'h000);
        exp_irq("irq_masked", 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_w1c_race();
        exp_t e;
        logic [31:0] a;
        din[2] = 1'b1;
        tick(6);
        bus_write(5'd1, 32'h004);
        exp_reg("race_set_wins", 5'd1, 32'h004);
        exp_reg("race_data",     5'd0, 32'h005);
        bus_write(5'd1, 32'h004);
        exp_reg("race_w1c_alone", 5'd1, 32'h000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_period_change();
        exp_t e;
        logic [31:0] a;
        bus_write(5'd4, 32'd100);
        din[5] = 1'b1;
        tick(32);
        exp_reg("shrink_before", 5'd0, 32'h005);
        bus_write(5'd4, 32'd10);
        exp_reg("shrink_write_edge", 5'd0, 32'h005);
        tick(1);
        exp_reg("shrink_next_edge", 5'd0, 32'h025);
        bus_write(5'd4, 32'd0);
        din[5] = 1'b0;
        tick(2);
        exp_reg("p0_edge2", 5'd0, 32'h025);
        tick(1);
        exp_reg("p0_edge3", 5'd0, 32'h005);
        exp_reg("p0_period", 5'd4, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [31:0] a;
        bus_write(5'd4, 32'd4);
        bus_write(5'd3, 32'h3FF);
        din = '0;
        tick(10);
        bus_write(5'd1, 32'h3FF);
        bus_write(5'd2, 32'h3FF);
        din = '1;
        tick(10);
        exp_reg("pre_rst_rise", 5'd1, 32'h3FF);
        exp_reg("pre_rst_data", 5'd0, 32'h3FF);
        exp_irq("pre_rst_irq", 1'b1);
        din = '0;
        tick(4);
        #2;
        reset_n = 1'b0;
        #1;
        exp_irq("rst_irq", 1'b0);
        exp_reg("rst_rise",   5'd1, 32'h000);
        exp_reg("rst_data",   5'd0, 32'h000);
        exp_reg("rst_fall",   5'd2, 32'h000);
        exp_reg("rst_ien",    5'd3, 32'h000);
        exp_reg("rst_period", 5'd4, 32'd500000);
        @(negedge clk);
        reset_n = 1'b1;
        tick(10);
        exp_reg("post_rst_rise", 5'd1, 32'h000);
        exp_reg("post_rst_fall", 5'd2, 32'h000);
        exp_reg("post_rst_data", 5'd0, 32'h000);
        bus_write(5'd7, 32'hFFFF_FFFF);
        exp_reg("addr7_read",   5'd7, 32'h000);
        exp_reg("addr7_period", 5'd4, 32'd500000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        din     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(1);

        test_reset();
        test_latency();
        test_glitch();
        test_irq();
        test_w1c_race();
        test_period_change();
        test_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpi_debounce_core.md
Name: gpi_debounce_core

Overview:
- FPro-bus MMIO slot core: N_IN-bit general-purpose input port with a per-bit debouncer, rising/falling edge capture and a maskable level interrupt.
- Plugs into one slot of the MMIO subsystem in place of a plain GPI core, for switches and keys.
- Successor to the plain GPI slot: parametrised width, runtime-programmable debounce period, edge latching, interrupt output.

Parameters:
- N_IN, 10, number of input bits (1..32).
- CNT_W, 20, debounce counter and period register width.
- DB_DEFAULT, 500000, reset value of the period register (10 ms at 50 MHz); must fit in CNT_W.

Ports:
- clk  in  1  system clock (fp_clk).
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  slot select.
- read  in  1  read strobe, qualified by cs.
- write  in  1  write strobe, qualified by cs.
- addr  in  5  slot register address.
- wr_data  in  32  write data.
- rd_data  out  32  read data, combinational from addr.
- din  in  N_IN  raw asynchronous inputs.
- irq  out  1  level interrupt.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - sync stages, debounced value db, per-bit counters, RISE, FALL and IEN are all cleared.
  - PERIOD is loaded with DB_DEFAULT.
  - irq=0.
- Synchroniser: 2-FF per bit (s1 then s2). All downstream logic uses s2 only.
- Per-bit debouncer, evaluated every clk edge:
  - if s2==db: cnt<=0.
  - else if cnt>=PERIOD: db<=s2 and cnt<=0.
  - else: cnt<=cnt+1.
  - The >= compare means lowering PERIOD mid-count flips the bit on the next edge. Counter never wraps.
- Latency: a din step sampled at edge 0 appears on db after edge PERIOD+3.
  - PERIOD=0 gives 3 edges total latency.
  - A pulse held in s2 for at most PERIOD cycles is suppressed.
- Edge capture:
  - On the edge where db bit i goes 0->1, set RISE[i]; on 1->0, set FALL[i].
  - Bits stay set until cleared by software.
- Register map. Write requires cs&write. Read data is combinational and ignores the read strobe; reads have no side effects.
  - addr 0 DATA: read {0, db}. Writes ignored.
  - addr 1 RISE: read {0, RISE}. Write-1-to-clear per bit.
  - addr 2 FALL: read {0, FALL}. Write-1-to-clear.
  - addr 3 IEN: R/W, bits[N_IN-1:0]. Upper bits read 0.
  - addr 4 PERIOD: R/W, bits[CNT_W-1:0]. Upper write bits ignored.
  - other addresses: read 0, writes ignored.
- Simultaneous edge-set and W1C on the same bit in the same cycle: set wins (the bit stays 1).
- irq = |((RISE|FALL) & IEN), registered: it updates one edge after the RISE/FALL/IEN change.
- A PERIOD write takes effect for the compare on the next edge. In-flight counters are not cleared.
- Reset asserted mid-count clears all state immediately. No edge is captured for the post-reset db value of 0.

Test Plan:
1. Reset release: check PERIOD reads 500000 and DATA, RISE, FALL, IEN and irq all read 0. Write PERIOD=4, then step din[0] 0->1 at edge 0 -> DATA bit0=1 after edge 7, not before; RISE=0x001; FALL=0.
2. PERIOD=4, din[3] glitch high for 4 cycles then low -> DATA, RISE and FALL stay 0. Same glitch for 8 cycles -> RISE bit3=1. After release, FALL bit3=1.
3. IEN=0x002, rise on bit1 -> irq=1 one edge after RISE bit1 sets. Write RISE=0x002 -> RISE=0, irq=0 on the following edge. Repeat with IEN=0 -> irq stays 0.
4. Program the W1C of RISE bit2 on the same edge that bit2's debounced rise occurs -> RISE bit2 reads 1 afterwards.
5. PERIOD=100, din[5] step, then after 30 cycles of counting write PERIOD=10 -> DATA bit5 flips on the edge after the write. PERIOD=0 -> a step is seen after 3 edges.
6. Assert reset_n=0 asynchronously, mid-count with RISE=0x3FF and IEN=0x3FF -> irq, RISE and DATA read 0 immediately. PERIOD=500000. Reads of addr 7 return 0.
